bus_master_port: RTL and testbench

BUS_MASTER_PORT -- requirements
Module: bus_master_port

---
 rtl/bus_master_port.sv | 170 +++++++++++++++++
 tb/tb_bus_master_port.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_port.sv
// Serial bus master port: latches one core request, arbitrates for the bus,
// shifts the address (and write data) out LSB first, collects read data
// LSB first, and reports completion with done/err.
module bus_master_port #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rw,
   input  logic [1:0]        slave_id,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              request,
   output logic [1:0]        slave_sel,
   input  logic              grant,
   output logic              bus_out,
   output logic              bus_valid,
   output logic              bus_rw,
   input  logic              bus_in,
   input  logic              bus_in_valid
);

   localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_DONE
   } state_t;

   state_t            state;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_sh;
   logic [DATA_W-1:0] wdata_sh;
   logic [CNT_W-1:0]  bit_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [DATA_W-1:0] rd_mask;   // one-hot position of the next read bit

   logic active, reading, grant_lost, capture, last_bit, wdata_end, time_up;
   logic finish, finish_err;

   // Completion/abort conditions shared by every bus-owning state.
   // NOTE: every signal here is assigned on every pass, so no latch is inferred.
   always_comb begin
      active     = state inside {S_ADDR, S_WDATA, S_RWAIT, S_RDATA};
      reading    = state inside {S_RWAIT, S_RDATA};
      grant_lost = active && !grant;
      capture    = reading && grant && bus_in_valid;
      last_bit   = capture && rd_mask[DATA_W-1];
      wdata_end  = (state == S_WDATA) && (bit_cnt == CNT_W'(DATA_W));
      time_up    = reading && (to_cnt == TO_W'(TIMEOUT - 1));
      finish     = grant_lost || wdata_end || last_bit || time_up;
      finish_err = grant_lost || (time_up && !last_bit);
   end

   // Transaction FSM; every output is a register updated with the state.
   // NOTE: state is written with non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rw_q      <= 1'b0;
         addr_sh   <= '0;
         wdata_sh  <= '0;
         bit_cnt   <= '0;
         to_cnt    <= '0;
         rd_mask   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         request   <= 1'b0;
         slave_sel <= 2'b00;
         bus_out   <= 1'b0;
         bus_valid <= 1'b0;
         bus_rw    <= 1'b0;
      end else begin
         if (capture) begin
            rdata   <= (rdata & ~rd_mask) | (bus_in ? rd_mask : '0);
            rd_mask <= rd_mask << 1;
         end
         if (active && finish) begin
            // Normal end, timeout or lost grant: release the bus at once.
            state     <= S_DONE;
            done      <= 1'b1;
            err       <= finish_err;
            request   <= 1'b0;
            slave_sel <= 2'b00;
            bus_valid <= 1'b0;
            bus_out   <= 1'b0;
            bus_rw    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     rw_q      <= rw;
                     addr_sh   <= addr;
                     wdata_sh  <= wdata;
                     rdata     <= '0;
                     rd_mask   <= DATA_W'(1);
                     busy      <= 1'b1;
                     request   <= 1'b1;
                     slave_sel <= slave_id;
                     state     <= S_REQ;
                  end
               end
               S_REQ: begin
                  // Wait indefinitely for the arbiter.
                  if (grant) begin
                     state     <= S_ADDR;
                     bus_valid <= 1'b1;
                     bus_rw    <= rw_q;
                     bus_out   <= addr_sh[0];
                     addr_sh   <= addr_sh >> 1;
                     bit_cnt   <= CNT_W'(1);
                  end
               end
               S_ADDR: begin
                  if (bit_cnt == CNT_W'(ADDR_W)) begin
                     bit_cnt <= CNT_W'(1);
                     if (rw_q) begin
                        state    <= S_WDATA;
                        bus_out  <= wdata_sh[0];
                        wdata_sh <= wdata_sh >> 1;
                     end else begin
                        state     <= S_RWAIT;
                        bus_valid <= 1'b0;
                        bus_out   <= 1'b0;
                        bus_rw    <= 1'b0;
                        to_cnt    <= '0;
                     end
                  end else begin
                     bus_out <= addr_sh[0];
                     addr_sh <= addr_sh >> 1;
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
               S_WDATA: begin
                  bus_out  <= wdata_sh[0];
                  wdata_sh <= wdata_sh >> 1;
                  bit_cnt  <= bit_cnt + CNT_W'(1);
               end
               S_RWAIT: begin
                  to_cnt <= to_cnt + TO_W'(1);
                  if (capture) state <= S_RDATA;
               end
               S_RDATA: begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
               S_DONE: begin
                  // A start seen here is deliberately dropped.
                  done  <= 1'b0;
                  err   <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: a cycle-indexed driver plays
// core, arbiter and slave; expectations come from the transaction rules
// (bit streams as packed numbers, latencies as arithmetic).
module tb_bus_master_port;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0, rw = 1'b0;
   logic [1:0]        slave_id = '0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] wdata = '0;
   logic              busy, done, err, request, bus_out, bus_valid, bus_rw;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        slave_sel;
   logic              grant = 1'b0, bus_in = 1'b0, bus_in_valid = 1'b0;

   int checks   = 0;
   int failures = 0;

   bus_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .slave_id(slave_id),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
      .rdata(rdata), .request(request), .slave_sel(slave_sel), .grant(grant),
      .bus_out(bus_out), .bus_valid(bus_valid), .bus_rw(bus_rw),
      .bus_in(bus_in), .bus_in_valid(bus_in_valid)
   );

   always #5 clk = ~clk;

   // Results of the last transaction. Cycle 0 is the cycle start is high;
   // cycle c is observed at the falling edge inside it.
   int                r_bits[$];
   int                r_done_cyc, r_first_valid, r_last_rd, r_proto;
   logic              r_err, r_busy_after, r_done_after, r_req_after;
   logic [DATA_W-1:0] r_rdata, r_rdata_after;

   function automatic logic [63:0] pack_bits(input int q[$]);
      logic [63:0] v = '0;
      foreach (q[i]) if (i < 64) v[i] = (q[i] != 0);
      return v;
   endfunction

   function automatic int max1(input int g);
      return (g < 1) ? 1 : g;
   endfunction

   // Drive one transaction and watch the port until done (bounded).
   // grant is high from cycle grant_on, low again from drop_at (if >= 0).
   // The slave sends rd_val LSB first from cycle rd_start with random gaps.
   task automatic run_txn(input logic t_rw, input logic [1:0] t_id,
                          input logic [ADDR_W-1:0] t_addr, input logic [DATA_W-1:0] t_wdata,
                          input int grant_on, input int drop_at, input bit rd_en,
                          input logic [DATA_W-1:0] rd_val, input int rd_start,
                          input bit busy_poke, input bit done_poke);
      int c = 0, nb = 0, next_rd = rd_start;
      bit seen = 0;
      r_bits.delete();
      r_proto = 0; r_done_cyc = -1; r_first_valid = -1; r_last_rd = -1;
      r_err = 1'b0; r_rdata = '0;
      @(negedge clk);
      start = 1'b1; rw = t_rw; slave_id = t_id; addr = t_addr; wdata = t_wdata;
      grant = (grant_on <= 0); bus_in_valid = 1'b0; bus_in = 1'b0;
      while (!seen && c < 300) begin
         @(negedge clk);
         c++;
         start    = busy_poke && (c == 3);
         rw       = 1'($urandom);
         slave_id = 2'($urandom);
         addr     = ADDR_W'($urandom);
         wdata    = DATA_W'($urandom);
         if (busy !== 1'b1) r_proto++;
         if (bus_valid === 1'b1) begin
            r_bits.push_back(int'(bus_out));
            if (r_first_valid < 0) r_first_valid = c;
            if (bus_rw !== t_rw) r_proto++;
         end else if (bus_rw !== 1'b0) r_proto++;
         if (request === 1'b1) begin
            if (slave_sel !== t_id) r_proto++;
         end else if (slave_sel !== 2'b00) r_proto++;
         if (done === 1'b1) begin
            seen = 1; r_done_cyc = c; r_err = err; r_rdata = rdata;
            if (request !== 1'b0 || bus_valid !== 1'b0) r_proto++;
         end else if (request !== 1'b1) r_proto++;
         grant = (c >= grant_on) && !(drop_at >= 0 && c >= drop_at);
         bus_in_valid = 1'b0; bus_in = 1'b0;
         if (!seen && rd_en && nb < DATA_W && c >= next_rd) begin
            bus_in_valid = 1'b1; bus_in = rd_val[nb]; nb++;
            r_last_rd = c; next_rd = c + 1 + $urandom_range(0, 3);
         end
         if (seen && done_poke) start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; bus_in_valid = 1'b0;
      r_busy_after = busy; r_done_after = done; r_req_after = request; r_rdata_after = rdata;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, err, rdata, request, slave_sel, bus_out, bus_valid, bus_rw} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b rdata=%h req=%b sel=%0d bv=%b bo=%b brw=%b, want all 0",
                  busy, done, err, rdata, request, slave_sel, bus_valid, bus_out, bus_rw);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || request !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: got busy=%b request=%b, want 0 0", busy, request);
      end
   endtask

   // Known write vector; done in cycle 1+1+ADDR_W+DATA_W+1 counting the
   // start cycle as 1, i.e. cycle index 22 here.
   task automatic test_write_vector();
      logic [63:0] exp_v = {44'd0, 8'h3C, 12'hA5C};
      run_txn(1'b1, 2'd2, 12'hA5C, 8'h3C, 0, -1, 0, '0, 0, 0, 0);
      checks++;
      if (r_done_cyc != 1 + ADDR_W + DATA_W + 1) begin
         failures++; $display("FAIL write_latency: got %0d want %0d", r_done_cyc, 1 + ADDR_W + DATA_W + 1);
      end
      checks++;
      if (r_err !== 1'b0) begin failures++; $display("FAIL write_err: got %b want 0", r_err); end
      checks++;
      if (r_bits.size() != ADDR_W + DATA_W || pack_bits(r_bits) !== exp_v) begin
         failures++;
         $display("FAIL write_stream: got %0d bits %h want %0d bits %h", r_bits.size(), pack_bits(r_bits), ADDR_W + DATA_W, exp_v);
      end
      checks++;
      if (r_first_valid != 2) begin failures++; $display("FAIL write_first_bit: got cycle %0d want 2", r_first_valid); end
      checks++;
      if (r_proto != 0) begin failures++; $display("FAIL write_protocol: got %0d violations want 0", r_proto); end
   endtask

   task automatic test_random_writes();
      for (int k = 0; k < 4; k++) begin
         logic [1:0]        id = 2'($urandom);
         logic [ADDR_W-1:0] a  = ADDR_W'($urandom);
         logic [DATA_W-1:0] d  = DATA_W'($urandom);
         int                g  = $urandom_range(0, 5);
         int                exp_done = max1(g) + 1 + ADDR_W + DATA_W;
         logic [63:0]       exp_v = 64'({d, a});
         run_txn(1'b1, id, a, d, g, -1, 0, '0, 0, 0, 1);
         checks++;
         if (r_done_cyc != exp_done || r_err !== 1'b0) begin
            failures++; $display("FAIL rand_write_done[%0d]: got cycle %0d err %b want cycle %0d err 0", k, r_done_cyc, r_err, exp_done);
         end
         checks++;
         if (r_bits.size() != ADDR_W + DATA_W || pack_bits(r_bits) !== exp_v) begin
            failures++; $display("FAIL rand_write_stream[%0d]: got %h want %h", k, pack_bits(r_bits), exp_v);
         end
         checks++;
         if (r_proto != 0) begin failures++; $display("FAIL rand_write_protocol[%0d]: got %0d want 0", k, r_proto); end
         checks++;
         if (r_busy_after !== 1'b0 || r_done_after !== 1'b0) begin
            failures++; $display("FAIL start_in_done_ignored[%0d]: got busy=%b done=%b want 0 0", k, r_busy_after, r_done_after);
         end
      end
   endtask

   task automatic test_delayed_grant();
      logic [63:0] exp_v = {44'd0, 8'h5A, 12'h3C1};
      run_txn(1'b1, 2'd1, 12'h3C1, 8'h5A, 11, -1, 0, '0, 0, 0, 0);
      checks++;
      if (r_first_valid != 12) begin failures++; $display("FAIL grant_wait_first_bit: got cycle %0d want 12", r_first_valid); end
      checks++;
      if (r_done_cyc != 11 + 1 + ADDR_W + DATA_W || r_err !== 1'b0) begin
         failures++; $display("FAIL grant_wait_done: got cycle %0d err %b want cycle %0d err 0", r_done_cyc, r_err, 12 + ADDR_W + DATA_W);
      end
      checks++;
      if (pack_bits(r_bits) !== exp_v || r_proto != 0) begin
         failures++; $display("FAIL grant_wait_stream: got %h violations %0d want %h 0", pack_bits(r_bits), r_proto, exp_v);
      end
   endtask

   task automatic test_read();
      for (int k = 0; k < 5; k++) begin
         logic [ADDR_W-1:0] a  = (k == 0) ? ADDR_W'(1) : ADDR_W'($urandom);
         logic [DATA_W-1:0] v  = (k == 0) ? DATA_W'(8'hB6) : DATA_W'($urandom);
         int                g  = (k == 0) ? 0 : $urandom_range(0, 3);
         int                r_entry = max1(g) + 1 + ADDR_W;
         int                off = (k == 0) ? 5 : $urandom_range(0, 6);
         run_txn(1'b0, 2'(k), a, '0, g, -1, 1, v, r_entry + off, 0, 0);
         checks++;
         if (r_done_cyc != r_last_rd + 1 || r_err !== 1'b0) begin
            failures++; $display("FAIL read_done[%0d]: got cycle %0d err %b want cycle %0d err 0", k, r_done_cyc, r_err, r_last_rd + 1);
         end
         checks++;
         if (r_rdata !== v || r_rdata_after !== v) begin
            failures++; $display("FAIL read_data[%0d]: got %h/%h want %h", k, r_rdata, r_rdata_after, v);
         end
         checks++;
         if (r_bits.size() != ADDR_W || pack_bits(r_bits) !== 64'(a) || r_proto != 0) begin
            failures++; $display("FAIL read_addr_stream[%0d]: got %0d bits %h violations %0d want %0d bits %h 0",
                                 k, r_bits.size(), pack_bits(r_bits), r_proto, ADDR_W, 64'(a));
         end
      end
   endtask

   task automatic test_timeout();
      int r_entry = 1 + 1 + ADDR_W;
      run_txn(1'b0, 2'd3, 12'h123, '0, 0, -1, 0, '0, 0, 0, 0);
      checks++;
      if (r_done_cyc != r_entry + TIMEOUT || r_err !== 1'b1) begin
         failures++; $display("FAIL read_timeout: got cycle %0d err %b want cycle %0d err 1", r_done_cyc, r_err, r_entry + TIMEOUT);
      end
      checks++;
      if (r_req_after !== 1'b0 || r_busy_after !== 1'b0 || r_proto != 0) begin
         failures++; $display("FAIL timeout_release: got req=%b busy=%b violations %0d want 0 0 0", r_req_after, r_busy_after, r_proto);
      end
   endtask

   task automatic test_grant_drop();
      // Address bit 4 goes out in cycle 1+1+4 = 6.
      run_txn(1'b1, 2'd2, 12'hFFF, 8'h81, 0, 6, 0, '0, 0, 0, 0);
      checks++;
      if (r_done_cyc != 7 || r_err !== 1'b1) begin
         failures++; $display("FAIL addr_grant_drop: got cycle %0d err %b want cycle 7 err 1", r_done_cyc, r_err);
      end
      checks++;
      if (r_bits.size() != 5 || r_req_after !== 1'b0 || r_proto != 0) begin
         failures++; $display("FAIL addr_grant_drop_bus: got %0d bits req=%b violations %0d want 5 0 0", r_bits.size(), r_req_after, r_proto);
      end
      // Same abort during read data collection.
      run_txn(1'b0, 2'd1, 12'h0F0, '0, 0, 1 + 1 + ADDR_W + 3, 1, 8'hFF, 1 + 1 + ADDR_W, 0, 0);
      checks++;
      if (r_done_cyc != 1 + 1 + ADDR_W + 4 || r_err !== 1'b1) begin
         failures++; $display("FAIL read_grant_drop: got cycle %0d err %b want cycle %0d err 1", r_done_cyc, r_err, ADDR_W + 6);
      end
   endtask

   task automatic test_reset_mid_wdata();
      int c = 0, nv = 0, ndone = 0;
      bit hit = 0;
      logic [63:0] exp_v = {44'd0, 8'hC3, 12'h7E5};
      @(negedge clk);
      start = 1'b1; rw = 1'b1; slave_id = 2'd1; addr = 12'h555; wdata = 8'hAA; grant = 1'b1;
      while (!hit && c < 60) begin
         @(negedge clk);
         c++; start = 1'b0;
         if (bus_valid === 1'b1) nv++;
         if (nv == ADDR_W + 3) hit = 1;
      end
      checks++;
      if (!hit) begin failures++; $display("FAIL reach_wdata: got %0d bus bits want %0d", nv, ADDR_W + 3); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, err, rdata, request, slave_sel, bus_out, bus_valid, bus_rw} !== '0) begin
         failures++;
         $display("FAIL async_reset: got busy=%b req=%b sel=%0d bv=%b bo=%b brw=%b want all 0",
                  busy, request, slave_sel, bus_valid, bus_out, bus_rw);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) ndone++;
      end
      checks++;
      if (ndone != 0) begin failures++; $display("FAIL no_done_after_reset: got %0d bad cycles want 0", ndone); end
      // Fresh transaction, with a second start thrown at it while busy.
      run_txn(1'b1, 2'd3, 12'h7E5, 8'hC3, 0, -1, 0, '0, 0, 1, 0);
      checks++;
      if (r_done_cyc != 1 + 1 + ADDR_W + DATA_W + 0 || r_err !== 1'b0 || pack_bits(r_bits) !== exp_v || r_proto != 0) begin
         failures++;
         $display("FAIL after_reset_write: got cycle %0d err %b stream %h violations %0d want cycle %0d err 0 stream %h 0",
                  r_done_cyc, r_err, pack_bits(r_bits), r_proto, ADDR_W + DATA_W + 2, exp_v);
      end
      checks++;
      if (r_busy_after !== 1'b0) begin failures++; $display("FAIL busy_start_ignored: got busy=%b want 0", r_busy_after); end
   endtask

   initial begin
      test_reset();
      test_write_vector();
      test_random_writes();
      test_delayed_grant();
      test_read();
      test_timeout();
      test_grant_drop();
      test_reset_mid_wdata();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
